// File: rtl/detector_pkg.sv
`default_nettype none
// ============================================================================
// Module : detector_pkg
// Shared state encoding and default timing for the detector emulator.
// Rev    : 1.0
// ============================================================================
package detector_pkg;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        IDLE    = 3'd1,
        ARMING  = 3'd2,
        EXPOSE  = 3'd3,
        READOUT = 3'd4
    } state_t;

    localparam int DET_ARM_DELAY       = 10;
    localparam int DET_EXPOSURE_CYCLES = 200;
    localparam int DET_READOUT_CYCLES  = 100;

    localparam logic [7:0] MISSED_MAX = 8'd255;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module : sync_edge_detect
// Multi-flop synchronizer followed by a delay flop for rising-edge detection.
// Rev    : 1.0
// ============================================================================
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_delay;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync  <= '0;
            r_delay <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_delay <= r_sync[SYNC_STAGES-1];
        end
    end

    assign sync_out = r_sync[SYNC_STAGES-1];
    assign rise     = r_sync[SYNC_STAGES-1] & ~r_delay;

endmodule
`default_nettype wire

// File: rtl/detector_responder.sv
`default_nettype none
// ============================================================================
// Module : detector_responder
// Detector emulator: trigger -> arm -> expose -> readout, with frame/missed counters.
// Rev    : 1.0
// ============================================================================
module detector_responder
    import detector_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int ARM_DELAY       = DET_ARM_DELAY,
    parameter int EXPOSURE_CYCLES = DET_EXPOSURE_CYCLES,
    parameter int READOUT_CYCLES  = DET_READOUT_CYCLES,
    parameter int FRAME_W         = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               trigger_in,
    output logic               detector_ready,
    output logic               exposing,
    output logic               frame_done,
    output logic [FRAME_W-1:0] frame_count,
    output logic [7:0]         missed_count,
    output logic [2:0]         state_o
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || EXPOSURE_CYCLES < 1 ||
            READOUT_CYCLES < 1 || ARM_DELAY < 0) begin : g_bad_params
            $error("detector_responder: illegal parameter value");
        end
    endgenerate

    localparam logic [31:0] c_arm_last = 32'(ARM_DELAY) - 32'd1;
    localparam logic [31:0] c_exp_last = 32'(EXPOSURE_CYCLES) - 32'd1;
    localparam logic [31:0] c_ro_last  = 32'(READOUT_CYCLES) - 32'd1;
    localparam state_t      c_after_idle = (ARM_DELAY == 0) ? EXPOSE : ARMING;
    localparam logic [FRAME_W-1:0] c_frame_one = {{(FRAME_W-1){1'b0}}, 1'b1};

    logic w_trig_sync;
    logic w_trig_rise;
    logic w_trig_edge;

    state_t             r_state;
    logic [31:0]        r_cnt;
    logic [FRAME_W-1:0] r_frame_count;
    logic [7:0]         r_missed;
    logic               r_frame_done;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_trig_sync (
        .clock   (clock),
        .reset   (reset),
        .async_in(trigger_in),
        .sync_out(w_trig_sync),
        .rise    (w_trig_rise)
    );

    assign w_trig_edge = w_trig_rise & w_trig_sync;

    // cnt counts cycles spent in the current state; every transition restarts it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= OFF;
            r_cnt         <= '0;
            r_frame_count <= '0;
            r_missed      <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_cnt        <= r_cnt + 32'd1;
            if (w_trig_edge && r_state != IDLE && r_missed != MISSED_MAX) begin
                r_missed <= r_missed + 8'd1;
            end
            if (!enable) begin
                r_state <= OFF;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    OFF: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                    IDLE: begin
                        if (w_trig_edge) begin
                            r_state <= c_after_idle;
                            r_cnt   <= '0;
                        end
                    end
                    ARMING: begin
                        if (r_cnt == c_arm_last) begin
                            r_state <= EXPOSE;
                            r_cnt   <= '0;
                        end
                    end
                    EXPOSE: begin
                        if (r_cnt == c_exp_last) begin
                            r_state <= READOUT;
                            r_cnt   <= '0;
                        end
                    end
                    READOUT: begin
                        if (r_cnt == c_ro_last) begin
                            r_state       <= IDLE;
                            r_cnt         <= '0;
                            r_frame_done  <= 1'b1;
                            r_frame_count <= r_frame_count + c_frame_one;
                        end
                    end
                    default: begin
                        r_state <= OFF;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign detector_ready = (r_state == IDLE) || (r_state == ARMING);
    assign exposing       = (r_state == EXPOSE);
    assign frame_done     = r_frame_done;
    assign frame_count    = r_frame_count;
    assign missed_count   = r_missed;
    assign state_o        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_detector_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_detector_responder
// Randomized bench: two detector configurations against a timeline model.
// Rev    : 1.0
// ============================================================================
module tb_detector_responder;

    localparam int EXP  = 20;
    localparam int RO   = 10;
    localparam int SYNC = 2;
    localparam int BIG  = 32'h3fff_ffff;

    typedef struct packed {
        int cyc;
        int fc;
    } frame_t;

    int arm_d[2] = '{4, 0};
    int fmask[2] = '{32'hffff, 32'hf};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        trigger_in = 1'b0;
    logic        rdy[2];
    logic        expo[2];
    logic        fd[2];
    logic [15:0] fc0;
    logic [3:0]  fc1;
    logic [7:0]  mc[2];
    logic [2:0]  st0;
    logic [2:0]  st1;

    always #5 clock = ~clock;

    detector_responder #(
        .SYNC_STAGES(SYNC), .ARM_DELAY(4), .EXPOSURE_CYCLES(EXP),
        .READOUT_CYCLES(RO), .FRAME_W(16)
    ) u_dut0 (
        .clock(clock), .reset(reset), .enable(enable), .trigger_in(trigger_in),
        .detector_ready(rdy[0]), .exposing(expo[0]), .frame_done(fd[0]),
        .frame_count(fc0), .missed_count(mc[0]), .state_o(st0)
    );

    detector_responder #(
        .SYNC_STAGES(SYNC), .ARM_DELAY(0), .EXPOSURE_CYCLES(EXP),
        .READOUT_CYCLES(RO), .FRAME_W(4)
    ) u_dut1 (
        .clock(clock), .reset(reset), .enable(enable), .trigger_in(trigger_in),
        .detector_ready(rdy[1]), .exposing(expo[1]), .frame_done(fd[1]),
        .frame_count(fc1), .missed_count(mc[1]), .state_o(st1)
    );

    // Timeline model: each accepted trigger owns the edge interval [d, d+ARM+EXP+RO).
    frame_t fq[2][$];
    int     win[2][$];
    int     missq[2][$];
    int     idle_start[2] = '{BIG, BIG};
    int     model_fc[2]   = '{0, 0};
    int     exp_missed[2] = '{0, 0};
    int     frames_seen[2] = '{0, 0};
    int     on_edge  = BIG;
    int     off_from = BIG;
    int     edge_n   = 0;
    int     checks   = 0;
    int     errors   = 0;
    bit     check_on = 1'b0;
    logic   prev_trig = 1'b0;
    logic   prev_en   = 1'b0;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d edge %0d: actual %0d required %0d",
                     name, k, edge_n, act, expv);
        end
    endtask

    // Drive one cycle of stimulus (sampled at the next edge) and predict its effect.
    task automatic step(input logic trig, input logic en);
        int     n;
        int     d;
        int     e;
        frame_t f;
        @(posedge clock);
        #1;
        n = edge_n;
        if (en != prev_en) begin
            if (en) begin
                on_edge  = n + 1;
                off_from = BIG;
                for (int k = 0; k < 2; k++) begin
                    idle_start[k] = n + 1;
                    win[k].delete();
                end
            end else begin
                off_from = n + 1;
                for (int k = 0; k < 2; k++) begin
                    idle_start[k] = BIG;
                    if (fq[k].size() > 0) begin
                        f = fq[k][fq[k].size()-1];
                        if (f.cyc >= n + 1) begin
                            void'(fq[k].pop_back());
                            model_fc[k]--;
                        end
                    end
                end
            end
        end
        if (trig && !prev_trig) begin
            d = n + 1 + SYNC;
            for (int k = 0; k < 2; k++) begin
                if (d > idle_start[k] && d < off_from) begin
                    e = d + arm_d[k] + EXP + RO;
                    win[k].push_back(d);
                    model_fc[k]++;
                    f.cyc = e;
                    f.fc  = model_fc[k];
                    fq[k].push_back(f);
                    idle_start[k] = e;
                end else begin
                    missq[k].push_back(d);
                end
            end
        end
        prev_trig  = trig;
        prev_en    = en;
        trigger_in = trig;
        enable     = en;
    endtask

    always @(negedge clock) begin
        int          n;
        bit          busy;
        bit          ex;
        bit          en_ok;
        frame_t      f;
        logic [31:0] fcv;
        if (check_on) begin
            n     = edge_n;
            en_ok = (n >= on_edge) && (n < off_from);
            for (int k = 0; k < 2; k++) begin
                while (win[k].size() > 0 && win[k][0] + arm_d[k] + EXP + RO <= n)
                    void'(win[k].pop_front());
                busy = (win[k].size() > 0) && (win[k][0] + arm_d[k] <= n);
                ex   = busy && (n < win[k][0] + arm_d[k] + EXP);
                while (missq[k].size() > 0 && missq[k][0] <= n) begin
                    void'(missq[k].pop_front());
                    if (exp_missed[k] < 255) exp_missed[k]++;
                end
                chk("detector_ready", k, rdy[k], en_ok && !busy);
                chk("exposing", k, expo[k], en_ok && ex);
                chk("missed_count", k, mc[k], exp_missed[k]);
                fcv = (k == 0) ? {16'd0, fc0} : {28'd0, fc1};
                if (fd[k] === 1'b1) begin
                    frames_seen[k]++;
                    if (fq[k].size() == 0) begin
                        chk("unexpected_frame_done", k, 1, 0);
                    end else begin
                        f = fq[k].pop_front();
                        chk("frame_done_edge", k, n, f.cyc);
                        chk("frame_count", k, fcv, f.fc & fmask[k]);
                    end
                end else if (fq[k].size() > 0 && fq[k][0].cyc <= n) begin
                    f = fq[k].pop_front();
                    chk("missing_frame_done", k, n, f.cyc);
                end
            end
        end
    end

    initial begin
        bit lvl;
        int hold;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset    = 1'b0;
        check_on = 1'b1;
        chk("reset_frame_count", 0, fc0, 0);
        chk("reset_frame_count", 1, fc1, 0);
        chk("reset_state", 0, st0, 0);

        // Edge while powered off is counted as missed.
        repeat (2) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);

        // Power up, then one trigger held high well past a whole frame.
        repeat (5) step(1'b0, 1'b1);
        repeat (100) step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b1);
        repeat (60) step(1'b0, 1'b1);

        // Random trigger waveform: mix of accepted and busy-time edges.
        lvl = 1'b0;
        for (int s = 0; s < 80; s++) begin
            lvl  = !lvl;
            hold = $urandom_range(1, 45);
            repeat (hold) step(lvl, 1'b1);
        end
        repeat (60) step(1'b0, 1'b1);

        // Drop enable on the fifth EXPOSE cycle of the ARM_DELAY=4 instance.
        repeat (11) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        repeat (60) step(1'b0, 1'b1);

        // Dense edge burst to drive missed_count into saturation.
        for (int i = 0; i < 600; i++) step((i % 2) == 0, 1'b1);
        repeat (80) step(1'b0, 1'b1);

        @(negedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("frames_pending", k, fq[k].size(), 0);
            chk("frame_total", k, frames_seen[k], model_fc[k]);
            chk("missed_saturated", k, mc[k], 255);
        end
        chk("frame_wrap_reached", 1, (frames_seen[1] >= 16), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/detector_responder.md
Name: detector_responder

Overview:
Detector-side end of the experiment trigger/ready handshake. It receives the experiment sequencer's output_trigger on trigger_in and drives detector_ready with the detector's real timing: arm delay, exposure, then readout. It is used as the hardware detector emulator for closed-loop bench runs, and as the front end of the detector interface board. It counts completed frames and counts triggers that arrive while the detector is busy.

Parameters:
SYNC_STAGES, 2, synchronizer flops on trigger_in (allowed values 2..4)
ARM_DELAY, 10, cycles from detected trigger edge to start of exposure (0 allowed)
EXPOSURE_CYCLES, 200, cycles exposing (minimum 1)
READOUT_CYCLES, 100, cycles of readout after exposure (minimum 1)
FRAME_W, 16, width of frame_count

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
enable  input  1  detector powered/armed; low forces OFF
trigger_in  input  1  asynchronous trigger from sequencer output_trigger
detector_ready  output  1  high = detector can accept a trigger
exposing  output  1  high during EXPOSE
frame_done  output  1  one-cycle pulse per completed frame
frame_count  output  FRAME_W  completed frames, wraps
missed_count  output  8  edges received outside IDLE, saturating
state_o  output  3  current state encoding, for debug

Behaviour:
- Reset: state OFF, all counters 0, synchronizer flops 0. Outputs: detector_ready=0, exposing=0, frame_done=0, frame_count=0, missed_count=0.
- Trigger path: SYNC_STAGES-flop synchronizer, then a delay flop. trig_edge = sync_out & ~sync_d (combinational).
- Outputs decoded from the state register:
  - detector_ready = (state==IDLE || state==ARMING)
  - exposing = (state==EXPOSE)
- frame_done is registered.
- One 32-bit up-counter cnt is cleared on every state entry.
- States (3-bit enum): OFF, IDLE, ARMING, EXPOSE, READOUT.
  - OFF: if enable, go to IDLE next cycle.
  - IDLE: on trig_edge, go to ARMING, or to EXPOSE directly if ARM_DELAY==0.
  - ARMING: stays exactly ARM_DELAY cycles, then EXPOSE.
  - EXPOSE: stays exactly EXPOSE_CYCLES cycles, then READOUT.
  - READOUT: stays exactly READOUT_CYCLES cycles, then IDLE. On that transition: frame_done=1 for one cycle (the first IDLE cycle), frame_count+1 modulo 2^FRAME_W.
- Latency: detector_ready falls SYNC_STAGES+ARM_DELAY clock edges after the first edge that samples trigger_in high. It stays low exactly EXPOSURE_CYCLES+READOUT_CYCLES cycles.
- Edge-triggered only. A trigger held high through a whole frame does not start a second frame; trigger_in must return low and rise again.
- trig_edge in any state other than IDLE: missed_count+1, saturating at 255, and no other effect. This includes an edge in the READOUT→IDLE transition cycle, which is missed.
- trig_edge in OFF is also counted as missed.
- enable low in any state: next cycle state=OFF, detector_ready=0, exposing=0. No frame_done, frame_count unchanged, cnt cleared.
- reset mid-frame: same as power-up reset, including clearing counters.
- reset has priority over enable; enable has priority over trigger.
- Illegal state encoding: go to OFF next cycle.

Decomposition:
- Package detector_pkg holds:
  - the state_t enum (OFF, IDLE, ARMING, EXPOSE, READOUT)
  - default constants DET_ARM_DELAY, DET_EXPOSURE_CYCLES, DET_READOUT_CYCLES
  - MISSED_MAX=255
- Sub-module sync_edge_detect(clock, reset, async_in, sync_out, rise): parameterized synchronizer plus rising-edge detect, reused by other async inputs (fg_signal, wire_signal).
- FSM and counters stay in detector_responder.

Test Plan:
Run with ARM_DELAY=4, EXPOSURE_CYCLES=20, READOUT_CYCLES=10, SYNC_STAGES=2 unless noted.
1. Reset, then enable=1 → detector_ready=1 one cycle later. Raise trigger_in → ready falls 6 cycles after the first sampling edge, exposing high 20 cycles, ready low 30 cycles total, then ready=1, frame_done single pulse, frame_count=1, missed_count=0.
2. During EXPOSE, drop trigger_in and raise it again → missed_count=1, frame timing unchanged, frame_count=1.
3. Hold trigger_in high for 100 cycles → exactly one frame, frame_count=1, missed_count=0. Then drop and raise → second frame, frame_count=2.
4. Deassert enable on EXPOSE cycle 5 → next cycle state OFF, ready=0, exposing=0, no frame_done, frame_count unchanged. Re-enable → ready=1 one cycle later.
5. Run with ARM_DELAY=0, FRAME_W=4 → ready falls 2 cycles after trigger. Run 16 frames → frame_count wraps to 0, 16 frame_done pulses.
6. Send 300 trigger edges while busy → missed_count saturates at 255. Closed loop with the experiment sequencer → its DETECTOR_WAIT exits on detector_ready rising, before the timeout.
